rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 integer register file between two sources: the in-order pipeline writeback and a long-latency unit (load/MUL-DIV) that returns results out of band.
- Holds a per-register busy scoreboard for outstanding long-latency destinations and raises the decode-stage stall on RAW/WAW hazards.
- Sits between the writeback stage, the long-latency unit and the register file write port.

Parameters:
- STARVE_MAX, 4: consecutive cycles a pending long-latency result may lose arbitration before the pipeline is forcibly held. Legal range 1..(2^CNT_W - 1).
- CNT_W, 3: width of the starvation counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- pipe_wen  in  1  pipeline writeback request
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  32  pipeline writeback data
- pipe_hold  out  1  pipeline must freeze WB and re-present its write next cycle
- ll_valid  in  1  long-latency result valid; held stable until ll_ready
- ll_ready  out  1  long-latency result accepted this cycle
- ll_waddr  in  5  long-latency destination register
- ll_wdata  in  32  long-latency result data
- dec_valid  in  1  decode-stage instruction valid
- dec_ll  in  1  decoded instruction is long-latency (marks rd busy on issue)
- dec_rs1, dec_rs2, dec_rd  in  5 each  decoded register indices
- dec_use_rs1, dec_use_rs2, dec_wr_rd  in  1 each  operand/destination in use
- dec_stall  out  1  decode must stall (hazard)
- rf_wen, rf_waddr, rf_wdata  out  1/5/32  register file write port
- busy_vec  out  32  scoreboard state (debug); bit 0 always 0

Behaviour:
- Reset (rst=1 at posedge): busy_vec=0, FSM=IDLE, cnt=0. Outputs after reset with inputs idle: rf_wen=0, ll_ready=1, pipe_hold=0, dec_stall=0.
- Write port is combinational, zero latency; the register file captures on the same edge.
- Arbitration: pipeline has priority except in FORCE.
  - ll_ready = FORCE | ~pipe_wen.
  - Grant ll when ll_valid & ll_ready; otherwise grant pipe when pipe_wen & ~FORCE.
  - rf_wen = grant & (granted addr != 0); rf_waddr/rf_wdata are from the grantee. With no grant: rf_wen=0, addr/data=0.
- Writes to x0 are accepted (ll_ready follows the rules above) but never drive rf_wen.
- FSM:
  - IDLE: ll_valid & pipe_wen -> WAIT, cnt=1.
  - WAIT: ll_valid & pipe_wen -> cnt+1. On reaching cnt==STARVE_MAX -> FORCE. If ll is granted -> IDLE, cnt=0.
  - FORCE: pipe_hold=1; ll is granted unconditionally and any pipe write is not performed; next state IDLE, cnt=0.
  - STARVE_MAX=1: first loss goes directly to FORCE.
- Scoreboard:
  - issue = dec_valid & dec_ll & dec_wr_rd & ~dec_stall & (dec_rd != 0); sets busy[dec_rd].
  - An ll commit (ll_valid & ll_ready) clears busy[ll_waddr].
  - Both update at the next edge.
  - Set and clear of the same register in one cycle: set wins.
- dec_stall = dec_valid & ((dec_use_rs1 & B[rs1]) | (dec_use_rs2 & B[rs2]) | (dec_wr_rd & B[rd])), where B = busy_vec. B[0] is always 0.
- Stall depends only on the registered busy_vec and this cycle's commit (see feature). It never depends on pipe_hold.
- Reset mid-operation clears the scoreboard and FSM. Outstanding ll results are discarded by the ll unit's own reset.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - B = busy_vec with the bit for ll_waddr masked off when an ll commit occurs this cycle.
  - The stall releases in the commit cycle; the register file write-through forwards the data.
  - Set/clear on the same register is then legal, and set wins.
- Undefined:
  - B = busy_vec; the stall releases one cycle after commit.
  - Set/clear on the same register cannot occur. A simulation assertion flags it.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> busy_vec=0, FSM IDLE. With inputs idle: rf_wen=0, ll_ready=1, pipe_hold=0, dec_stall=0.
- Issue dec_ll, rd=5 -> busy_vec[5]=1 next cycle; decode rs1=5 -> dec_stall=1. ll_valid x5=0xDEADBEEF with pipe idle -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Stall drops the next cycle (same cycle with WB_BYPASS_EN).
- Collision: pipe x3=0x11 and ll x7=0x22 in the same cycle -> rf writes x3, ll_ready=0. Next cycle with pipe idle -> rf writes x7=0x22, ll_ready=1, FSM returns to IDLE.
- Starvation, STARVE_MAX=4: pipe_wen=1 every cycle, ll_valid held -> 4 cycles with ll_ready=0. 5th cycle: pipe_hold=1, rf writes the ll data, ll_ready=1. Following cycle: pipe write resumes.
- x0: issue dec_ll rd=0 -> busy_vec unchanged. ll_valid to x0 -> ll_ready=1, rf_wen=0.
- WAW plus mid-operation reset: rd=9 busy, decode with dec_wr_rd rd=9 -> dec_stall=1. Assert rst while in WAIT -> busy_vec=0 and dec_stall=0 the next cycle.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter (pipeline vs long-latency unit) with a busy scoreboard for RAW/WAW stalls.
// Optional macro WB_BYPASS_EN: release the decode stall in the same cycle as the long-latency commit.
module rf_wb_scheduler #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_hold,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_waddr,
  input  logic [31:0] ll_wdata,
  input  logic        dec_valid,
  input  logic        dec_ll,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic        dec_wr_rd,
  output logic        dec_stall,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_vec
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [31:0]      busy_q, busy_nxt, b_eff;
  logic             force_st, ll_commit, pipe_grant, lose, issue;

  // Handshake: the ll result is transferred on any cycle where ll_valid and ll_ready are both high;
  // ll_valid and its address/data stay stable until then. The pipeline write is performed unless
  // an ll transfer takes the port, and pipe_hold tells the pipeline to re-present it next cycle.
  assign force_st   = (state == ST_FORCE);
  assign ll_ready   = force_st | ~pipe_wen;
  assign ll_commit  = ll_valid & ll_ready;
  assign pipe_grant = pipe_wen & ~force_st & ~ll_commit;
  assign pipe_hold  = force_st;
  assign lose       = ll_valid & pipe_wen & ~force_st;
  assign cnt_inc    = cnt + CNT_W'(1);

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (ll_commit) begin
      rf_wen   = (ll_waddr != 5'd0);
      rf_waddr = ll_waddr;
      rf_wdata = ll_wdata;
    end else if (pipe_grant) begin
      rf_wen   = (pipe_waddr != 5'd0);
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (lose) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = (STARVE_MAX == 1) ? ST_FORCE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ll_commit || !ll_valid) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (lose) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_W'(STARVE_MAX)) state_nxt = ST_FORCE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef WB_BYPASS_EN
  logic [31:0] commit_mask;
  assign commit_mask = ll_commit ? (32'd1 << ll_waddr) : 32'd0;
  assign b_eff       = busy_q & ~commit_mask;
`else
  assign b_eff = busy_q;
`endif

  assign dec_stall = dec_valid & ((dec_use_rs1 & b_eff[dec_rs1]) |
                                  (dec_use_rs2 & b_eff[dec_rs2]) |
                                  (dec_wr_rd   & b_eff[dec_rd]));
  assign issue     = dec_valid & dec_ll & dec_wr_rd & ~dec_stall & (dec_rd != 5'd0);

  // Set is applied after clear so a same-register set/clear leaves the register busy.
  always_comb begin
    busy_nxt = busy_q;
    if (ll_commit) busy_nxt[ll_waddr] = 1'b0;
    if (issue)     busy_nxt[dec_rd]   = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

`ifndef WB_BYPASS_EN
  // Without bypass a busy destination always stalls, so an issue can never meet a commit to the same rd.
  a_no_set_clr: assert property (@(posedge clk) disable iff (rst)
    !(issue && ll_commit && (dec_rd == ll_waddr)));
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: inline per-scenario checks plus a write-port scoreboard.
module tb_rf_wb_scheduler;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_hold;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_waddr;
  logic [31:0] ll_wdata;
  logic        dec_valid, dec_ll;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_wr_rd;
  logic        dec_stall;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [36:0] exp_q[$];

  rf_wb_scheduler #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_hold(pipe_hold),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .dec_valid(dec_valid), .dec_ll(dec_ll), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .dec_stall(dec_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard: every rf write seen must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en && rf_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=%h, expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wen = 0; pipe_waddr = 0; pipe_wdata = 0;
    ll_valid = 0; ll_waddr = 0; ll_wdata = 0;
    dec_valid = 0; dec_ll = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr_rd = 0;
  endtask

  task automatic random_inputs();
    pipe_wen = 1'($urandom_range(1)); pipe_waddr = 5'($urandom_range(31)); pipe_wdata = $urandom;
    ll_valid = 1'($urandom_range(1)); ll_waddr = 5'($urandom_range(31)); ll_wdata = $urandom;
    dec_valid = 1'($urandom_range(1)); dec_ll = 1'($urandom_range(1));
    dec_rs1 = 5'($urandom_range(31)); dec_rs2 = 5'($urandom_range(31)); dec_rd = 5'($urandom_range(31));
    dec_use_rs1 = 1'($urandom_range(1)); dec_use_rs2 = 1'($urandom_range(1));
    dec_wr_rd = 1'($urandom_range(1));
  endtask

  task automatic issue_ll(input logic [4:0] rd);
    idle_inputs();
    dec_valid = 1; dec_ll = 1; dec_wr_rd = 1; dec_rd = rd;
  endtask

  task automatic test_reset();
    mon_en = 0;
    step(); rst = 1; random_inputs();
    step(); random_inputs();
    step(); rst = 0; idle_inputs();
    @(negedge clk);
    checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h, expected 0", busy_vec); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen: got %b, expected 0", rf_wen); end
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL reset_ll_ready: got %b, expected 1", ll_ready); end
    checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_pipe_hold: got %b, expected 0", pipe_hold); end
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL reset_dec_stall: got %b, expected 0", dec_stall); end
    mon_en = 1;
  endtask

  task automatic test_raw();
    logic exp_commit_stall;
`ifdef WB_BYPASS_EN
    exp_commit_stall = 1'b0;
`else
    exp_commit_stall = 1'b1;
`endif
    step(); issue_ll(5'd5);
    @(negedge clk);
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall: got %b, expected 0", dec_stall); end
    step(); idle_inputs(); dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd5;
    @(negedge clk);
    checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy_set: got %h, expected 00000020", busy_vec); end
    checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b, expected 1", dec_stall); end
    step(); ll_valid = 1; ll_waddr = 5'd5; ll_wdata = 32'hDEAD_BEEF;
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    @(negedge clk);
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL raw_ll_ready: got %b, expected 1", ll_ready); end
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL raw_rf_wen: got %b, expected 1", rf_wen); end
    checks++; if (dec_stall !== exp_commit_stall) begin errors++; $display("FAIL raw_commit_stall: got %b, expected %b", dec_stall, exp_commit_stall); end
    step(); ll_valid = 0;
    @(negedge clk);
    checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL raw_busy_clear: got %h, expected 0", busy_vec); end
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_release: got %b, expected 0", dec_stall); end
    step(); idle_inputs();
  endtask

  task automatic test_collision();
    step(); idle_inputs();
    pipe_wen = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
    ll_valid = 1; ll_waddr = 5'd7; ll_wdata = 32'h22;
    exp_q.push_back({5'd3, 32'h11});
    @(negedge clk);
    checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL coll_ll_ready: got %b, expected 0", ll_ready); end
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL coll_rf_wen: got %b, expected 1", rf_wen); end
    step(); pipe_wen = 0;
    exp_q.push_back({5'd7, 32'h22});
    @(negedge clk);
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL coll_ll_ready2: got %b, expected 1", ll_ready); end
    checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL coll_pipe_hold: got %b, expected 0", pipe_hold); end
    step(); idle_inputs();
  endtask

  // Also confirms the FSM starts this scenario in IDLE: exactly STARVE_MAX losses precede the hold.
  task automatic test_starvation();
    logic [31:0] ll_d, pd;
    logic [4:0]  pa;
    ll_d = $urandom;
    for (int i = 0; i < STARVE_MAX; i++) begin
      step(); idle_inputs();
      ll_valid = 1; ll_waddr = 5'd12; ll_wdata = ll_d;
      pipe_wen = 1; pipe_waddr = 5'(i + 1); pipe_wdata = $urandom;
      exp_q.push_back({pipe_waddr, pipe_wdata});
      @(negedge clk);
      checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL starve_ll_ready[%0d]: got %b, expected 0", i, ll_ready); end
      checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL starve_hold[%0d]: got %b, expected 0", i, pipe_hold); end
    end
    pa = 5'd20; pd = $urandom;
    step(); pipe_waddr = pa; pipe_wdata = pd;
    exp_q.push_back({5'd12, ll_d});
    @(negedge clk);
    checks++; if (pipe_hold !== 1'b1) begin errors++; $display("FAIL starve_force_hold: got %b, expected 1", pipe_hold); end
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL starve_force_ready: got %b, expected 1", ll_ready); end
    step(); ll_valid = 0;
    exp_q.push_back({pa, pd});
    @(negedge clk);
    checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL starve_resume_hold: got %b, expected 0", pipe_hold); end
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL starve_resume_wen: got %b, expected 1", rf_wen); end
    step(); idle_inputs();
  endtask

  task automatic test_x0();
    step(); issue_ll(5'd0);
    @(negedge clk);
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL x0_issue_stall: got %b, expected 0", dec_stall); end
    step(); idle_inputs();
    @(negedge clk);
    checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL x0_busy: got %h, expected 0", busy_vec); end
    step(); ll_valid = 1; ll_waddr = 5'd0; ll_wdata = $urandom;
    @(negedge clk);
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL x0_ll_ready: got %b, expected 1", ll_ready); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_rf_wen: got %b, expected 0", rf_wen); end
    step(); idle_inputs();
  endtask

  task automatic test_waw_reset();
    step(); issue_ll(5'd9);
    step(); idle_inputs(); dec_valid = 1; dec_wr_rd = 1; dec_rd = 5'd9;
    @(negedge clk);
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL waw_busy: got %h, expected 00000200", busy_vec); end
    checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b, expected 1", dec_stall); end
    step(); pipe_wen = 1; pipe_waddr = 5'd2; pipe_wdata = 32'h5A5A_0002;
    ll_valid = 1; ll_waddr = 5'd9; ll_wdata = 32'h0000_0009;
    exp_q.push_back({5'd2, 32'h5A5A_0002});
    @(negedge clk);
    checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL waw_wait_ready: got %b, expected 0", ll_ready); end
    step(); rst = 1; pipe_wen = 0; ll_valid = 0;
    step(); rst = 0;
    @(negedge clk);
    checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL waw_rst_busy: got %h, expected 0", busy_vec); end
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL waw_rst_stall: got %b, expected 0", dec_stall); end
    step(); idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      step(); idle_inputs();
      pipe_wen = 1; pipe_waddr = 5'($urandom_range(31)); pipe_wdata = $urandom;
      if (pipe_waddr != 5'd0) exp_q.push_back({pipe_waddr, pipe_wdata});
      @(negedge clk);
      checks++; if (rf_wen !== (pipe_waddr != 5'd0)) begin errors++; $display("FAIL b2b_rf_wen[%0d]: got %b, expected %b", i, rf_wen, pipe_waddr != 5'd0); end
    end
    step(); idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_raw();
    test_collision();
    test_starvation();
    test_x0();
    test_waw_reset();
    test_starvation();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
